// File: rtl/axil_mem_bridge.sv
// Memory-port to AXI4-Lite master bridge: one single-beat read or write per request,
// with byte strobes, independent AW/W handshakes, error status and a response timeout.
module axil_mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      i_mem_clk,
    input  logic                      i_mem_rst,
    input  logic                      i_mem_cs,
    input  logic                      i_mem_we,
    input  logic [ADDR_WIDTH-1:0]     i_mem_addr,
    input  logic [DATA_WIDTH-1:0]     i_mem_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_mem_be,
    output logic                      o_mem_ready,
    output logic                      o_mem_done,
    output logic                      o_mem_err,
    output logic [DATA_WIDTH-1:0]     o_mem_rdata,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic [2:0]                AWPROT,
    output logic                      WVALID,
    input  logic                      WREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      BVALID,
    output logic                      BREADY,
    input  logic [1:0]                BRESP,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic [2:0]                ARPROT,
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic [1:0]                RRESP,
    input  logic [DATA_WIDTH-1:0]     RDATA
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_width_check
        $error("axil_mem_bridge: DATA_WIDTH must be 32 or 64");
    end

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ready_d, done_d, err_d;
    logic [DATA_WIDTH-1:0]   rdata_d, wdata_d;
    logic                    awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_d, araddr_d;
    logic [STRB_W-1:0]       wstrb_d;
    logic                    resp_timeout;
    logic                    aw_done, w_done;

    assign AWPROT = 3'b000;
    assign ARPROT = 3'b000;

    // Last waiting cycle: the response must arrive now or the request is abandoned.
    assign resp_timeout = TO_EN && (cnt_q == TO_LAST);
    assign aw_done      = !AWVALID || AWREADY;
    assign w_done       = !WVALID || WREADY;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = o_mem_ready;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rdata_d   = o_mem_rdata;
        awvalid_d = AWVALID;
        wvalid_d  = WVALID;
        bready_d  = BREADY;
        arvalid_d = ARVALID;
        rready_d  = RREADY;
        awaddr_d  = AWADDR;
        araddr_d  = ARADDR;
        wdata_d   = WDATA;
        wstrb_d   = WSTRB;

        case (state_q)
            IDLE: begin
                if (i_mem_cs) begin
                    ready_d = 1'b0;
                    if (i_mem_we) begin
                        awaddr_d  = i_mem_addr;
                        wdata_d   = i_mem_wdata;
                        wstrb_d   = i_mem_be;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = i_mem_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (AWVALID && AWREADY) awvalid_d = 1'b0;
                if (WVALID && WREADY)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID || resp_timeout) begin
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = BVALID ? (BRESP != 2'b00) : 1'b1;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_REQ: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (RVALID || resp_timeout) begin
                    rready_d = 1'b0;
                    done_d   = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                    if (RVALID) begin
                        rdata_d = RDATA;
                        err_d   = (RRESP != 2'b00);
                    end else begin
                        err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_mem_clk) begin
        if (i_mem_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            o_mem_ready <= 1'b1;
            o_mem_done  <= 1'b0;
            o_mem_err   <= 1'b0;
            o_mem_rdata <= '0;
            AWVALID     <= 1'b0;
            WVALID      <= 1'b0;
            BREADY      <= 1'b0;
            ARVALID     <= 1'b0;
            RREADY      <= 1'b0;
            AWADDR      <= '0;
            ARADDR      <= '0;
            WDATA       <= '0;
            WSTRB       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            o_mem_ready <= ready_d;
            o_mem_done  <= done_d;
            o_mem_err   <= err_d;
            o_mem_rdata <= rdata_d;
            AWVALID     <= awvalid_d;
            WVALID      <= wvalid_d;
            BREADY      <= bready_d;
            ARVALID     <= arvalid_d;
            RREADY      <= rready_d;
            AWADDR      <= awaddr_d;
            ARADDR      <= araddr_d;
            WDATA       <= wdata_d;
            WSTRB       <= wstrb_d;
        end
    end
endmodule
